// File: rtl/vq_pkg.sv
// Shared VQ definitions: geometry, FSM state encoding and word typedefs.
// Used by the compressor controller and by vq_decompressor.
package vq_pkg;
    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 18;
    localparam int IDX_W   = 6;
    localparam int NUM_VEC = 4096;
    localparam int CB_SIZE = 2 ** IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CB,
        DECODE,
        DRAIN,
        FINISH
    } state_t;

    typedef logic [DATA_W-1:0] codeword_t;
    typedef logic [IDX_W-1:0]  tag_t;
endpackage

// File: rtl/vq_codebook_rf.sv
// Codebook register file: CB_SIZE x DATA_W, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module vq_codebook_rf
    import vq_pkg::*;
(
    input  logic      clk,
    input  logic      i_we,
    input  tag_t      i_wa,
    input  codeword_t i_wd,
    input  tag_t      i_ra,
    output codeword_t o_rd
);
    codeword_t r_mem [CB_SIZE];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wa] <= i_wd;
    end

    assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/vq_decompressor.sv
// VQ decompressor: loads the codebook from RAM_W, then streams tags from RAM_TAG
// through a 2-stage lookup into RAM_OUT. Optional VQ_DECOMP_CHECKSUM_EN adds a write checksum.
module vq_decompressor
    import vq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              RAM_W_OE,
    output logic [ADDR_W-1:0] RAM_W_A,
    input  logic [DATA_W-1:0] RAM_W_Q,
    output logic              RAM_TAG_OE,
    output logic [ADDR_W-1:0] RAM_TAG_A,
    input  logic [DATA_W-1:0] RAM_TAG_Q,
    output logic              RAM_OUT_WE,
    output logic [ADDR_W-1:0] RAM_OUT_A,
    output logic [DATA_W-1:0] RAM_OUT_D,
    output logic              busy,
    output logic              done
`ifdef VQ_DECOMP_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    state_t              r_state, w_state_nxt;
    logic                r_drain_2nd;
    logic                r_w_oe, r_tag_oe, r_vld_p1, r_out_we, r_cb_we;
    logic [ADDR_W-1:0]   r_w_a, r_tag_a, r_p1_a, r_out_a;
    tag_t                r_cb_wa;
    codeword_t           r_out_d, w_cw;
    logic                r_busy, r_done;
    logic                w_last_cb, w_last_tag, w_run_start;
    logic                w_unused_tag_hi;

    assign w_last_cb       = (r_w_a == ADDR_W'(CB_SIZE - 1));
    assign w_last_tag      = (r_tag_a == ADDR_W'(NUM_VEC - 1));
    assign w_unused_tag_hi = ^RAM_TAG_Q[DATA_W-1:IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain_2nd <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_2nd <= (r_state == DRAIN) && !r_drain_2nd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        case (r_state)
            IDLE, FINISH: if (start) begin
                w_state_nxt = LOAD_CB;
                w_run_start = 1'b1;
            end
            LOAD_CB: if (w_last_cb)   w_state_nxt = DECODE;
            DECODE:  if (w_last_tag)  w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_2nd) w_state_nxt = FINISH;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each issue lands in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_oe   <= 1'b0;
            r_w_a    <= '0;
            r_tag_oe <= 1'b0;
            r_tag_a  <= '0;
            r_cb_we  <= 1'b0;
            r_cb_wa  <= '0;
            r_vld_p1 <= 1'b0;
            r_p1_a   <= '0;
            r_out_we <= 1'b0;
            r_out_a  <= '0;
            r_out_d  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_w_oe <= (w_state_nxt == LOAD_CB);
            if (w_state_nxt == LOAD_CB)
                r_w_a <= (r_state == LOAD_CB) ? r_w_a + ADDR_W'(1) : '0;
            r_tag_oe <= (w_state_nxt == DECODE);
            if (w_state_nxt == DECODE)
                r_tag_a <= (r_state == DECODE) ? r_tag_a + ADDR_W'(1) : '0;
            r_cb_we  <= r_w_oe;
            r_cb_wa  <= r_w_a[IDX_W-1:0];
            r_vld_p1 <= r_tag_oe;
            r_p1_a   <= r_tag_a;
            r_out_we <= r_vld_p1;
            if (r_vld_p1) begin
                r_out_a <= r_p1_a;
                r_out_d <= w_cw;
            end
            r_busy <= (w_state_nxt == LOAD_CB) || (w_state_nxt == DECODE) ||
                      (w_state_nxt == DRAIN);
            r_done <= (w_state_nxt == FINISH);
        end
    end

    // Last codebook write commits in the first DECODE cycle, before the first lookup.
    vq_codebook_rf u_cb (
        .clk  (clk),
        .i_we (r_cb_we),
        .i_wa (r_cb_wa),
        .i_wd (RAM_W_Q),
        .i_ra (RAM_TAG_Q[IDX_W-1:0]),
        .o_rd (w_cw)
    );

`ifdef VQ_DECOMP_CHECKSUM_EN
    logic [31:0] r_csum;
    always_ff @(posedge clk) begin
        if (rst)              r_csum <= '0;
        else if (w_run_start) r_csum <= '0;
        else if (r_out_we)    r_csum <= r_csum + 32'(r_out_d);
    end
    assign checksum = r_csum;
`endif

    assign RAM_W_OE   = r_w_oe;
    assign RAM_W_A    = r_w_a;
    assign RAM_TAG_OE = r_tag_oe;
    assign RAM_TAG_A  = r_tag_a;
    assign RAM_OUT_WE = r_out_we;
    assign RAM_OUT_A  = r_out_a;
    assign RAM_OUT_D  = r_out_d;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_vq_decompressor.sv
// Directed bench for vq_decompressor: SRAM models, a negedge protocol monitor,
// full-image data scans and a table of hand-computed spot values.
module tb_vq_decompressor;
    import vq_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start;
    logic              RAM_W_OE, RAM_TAG_OE, RAM_OUT_WE, busy, done;
    logic [ADDR_W-1:0] RAM_W_A, RAM_TAG_A, RAM_OUT_A;
    logic [DATA_W-1:0] RAM_W_Q, RAM_TAG_Q, RAM_OUT_D;
`ifdef VQ_DECOMP_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    always #5 clk = ~clk;

    vq_decompressor dut (
        .clk(clk), .rst(rst), .start(start),
        .RAM_W_OE(RAM_W_OE), .RAM_W_A(RAM_W_A), .RAM_W_Q(RAM_W_Q),
        .RAM_TAG_OE(RAM_TAG_OE), .RAM_TAG_A(RAM_TAG_A), .RAM_TAG_Q(RAM_TAG_Q),
        .RAM_OUT_WE(RAM_OUT_WE), .RAM_OUT_A(RAM_OUT_A), .RAM_OUT_D(RAM_OUT_D),
        .busy(busy), .done(done)
`ifdef VQ_DECOMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    logic [23:0] cb_mem  [64];
    logic [23:0] tag_mem [4096];
    logic [23:0] out_d_mem [4096];
    int          out_run [4096];
    int          run_id = 0;
    int          checks = 0, failures = 0;

    // Synchronous single-port read SRAMs: data one cycle after OE/A.
    always @(posedge clk) begin
        if (RAM_W_OE)   RAM_W_Q   <= cb_mem[RAM_W_A[5:0]];
        if (RAM_TAG_OE) RAM_TAG_Q <= tag_mem[RAM_TAG_A[11:0]];
    end

    // Protocol monitor
    int          cyc = 0, wr_cnt = 0, mon_err = 0;
    int          last_w_cyc = -100, first_t_cyc = -200;
    logic        h1_oe = 1'b0, h2_oe = 1'b0;
    logic [17:0] h1_a = '0, h2_a = '0, exp_w_a = '0, exp_t_a = '0, exp_o_a = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        mon_err <= mon_err + (((RAM_OUT_WE !== h2_oe) ||
                               (RAM_OUT_WE && ((RAM_OUT_A !== h2_a) || (RAM_OUT_A !== exp_o_a))) ||
                               (RAM_W_OE && (RAM_W_A !== exp_w_a)) ||
                               (RAM_TAG_OE && (RAM_TAG_A !== exp_t_a))) ? 1 : 0);
        if (RAM_OUT_WE) begin
            wr_cnt <= wr_cnt + 1;
            out_d_mem[RAM_OUT_A[11:0]] <= RAM_OUT_D;
            out_run[RAM_OUT_A[11:0]]   <= run_id;
        end
        if (rst || start) begin
            h1_oe <= 1'b0; h2_oe <= 1'b0; h1_a <= '0; h2_a <= '0;
            exp_w_a <= '0; exp_t_a <= '0; exp_o_a <= '0;
            last_w_cyc <= -100; first_t_cyc <= -200;
        end else begin
            h2_oe <= h1_oe; h2_a <= h1_a;
            h1_oe <= RAM_TAG_OE; h1_a <= RAM_TAG_A;
            if (RAM_W_OE)   exp_w_a <= RAM_W_A + 18'd1;
            if (RAM_TAG_OE) exp_t_a <= RAM_TAG_A + 18'd1;
            if (RAM_OUT_WE) exp_o_a <= RAM_OUT_A + 18'd1;
            if (RAM_W_OE && RAM_W_A == 18'd63)  last_w_cyc  <= cyc;
            if (RAM_TAG_OE && RAM_TAG_A == 18'd0) first_t_cyc <= cyc;
        end
    end

    typedef struct {
        int          run;
        int          addr;
        logic [23:0] exp;
    } spot_t;
    spot_t spots [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_run(input string nm);
        int n, e0, w0, bad;
        run_id++;
        e0 = mon_err; w0 = wr_cnt; bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 1;
        chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
        chk({nm, "_done_low"}, 32'(done), 32'd0);
        while (!done && n < 6000) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_len"}, n, 32'd4163);
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        chk({nm, "_writes"}, wr_cnt - w0, 32'd4096);
        chk({nm, "_protocol"}, mon_err - e0, 32'd0);
        chk({nm, "_cb_before_tag"}, first_t_cyc - last_w_cyc, 32'd1);
        for (int k = 0; k < 4096; k++)
            if (out_run[k] != run_id || out_d_mem[k] !== cb_mem[tag_mem[k][5:0]]) bad++;
        chk({nm, "_data_scan"}, bad, 32'd0);
        for (int s = 0; s < 13; s++)
            if (spots[s].run == run_id)
                chk($sformatf("%s_spot%0d", nm, spots[s].addr), 32'(out_d_mem[spots[s].addr]),
                    32'(spots[s].exp));
    endtask

    initial begin
        int n, w0;
        spots[0]  = '{1, 0,    24'h000000};
        spots[1]  = '{1, 1,    24'h010001};
        spots[2]  = '{1, 63,   24'h3F003F};
        spots[3]  = '{1, 100,  24'h240024};
        spots[4]  = '{1, 2050, 24'h020002};
        spots[5]  = '{1, 4095, 24'h3F003F};
        spots[6]  = '{2, 0,    24'hA53FC0};
        spots[7]  = '{2, 5,    24'hA505FA};
        spots[8]  = '{2, 13,   24'hA501FE};
        spots[9]  = '{2, 4095, 24'hA53BC4};
        spots[10] = '{4, 0,    24'h00007F};
        spots[11] = '{4, 10,   24'h000075};
        spots[12] = '{4, 4095, 24'h000040};

        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enables", {29'd0, RAM_W_OE, RAM_TAG_OE, RAM_OUT_WE}, 32'd0);
        chk("rst_addrs", 32'(RAM_W_A | RAM_TAG_A | RAM_OUT_A), 32'd0);
        chk("rst_out_d", 32'(RAM_OUT_D), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
`ifdef VQ_DECOMP_CHECKSUM_EN
        chk("rst_csum", checksum, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic run from IDLE
        for (int i = 0; i < 64; i++) cb_mem[i] = 24'h010000 * 24'(i) + 24'(i);
        for (int k = 0; k < 4096; k++) tag_mem[k] = 24'(k % 64);
        do_run("basic");

        // Restart from FINISH with new codebook and garbage in the upper tag bits
        for (int i = 0; i < 64; i++) cb_mem[i] = {8'hA5, 2'b00, 6'(i), ~{2'b00, 6'(i)}};
        for (int k = 0; k < 4096; k++) tag_mem[k] = {18'(k) ^ 18'h2AAAA, 6'((k * 5) % 64)};
        tag_mem[0] = 24'hFFFFFF;
        tag_mem[5] = 24'hFFFFC5;
        do_run("restart");

        // Reset in the middle of decode
        run_id++;
        for (int i = 0; i < 64; i++) cb_mem[i] = 24'h010000 * 24'(i) + 24'(i);
        for (int k = 0; k < 4096; k++) tag_mem[k] = 24'(k % 64);
        w0 = wr_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        while (!(RAM_TAG_OE && RAM_TAG_A == 18'd1000) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_mid_reach", 32'(RAM_TAG_A), 32'd1000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_enables", {29'd0, RAM_W_OE, RAM_TAG_OE, RAM_OUT_WE}, 32'd0);
        chk("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_mid_writes", wr_cnt - w0, 32'd999);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_no_writes", wr_cnt - w0, 32'd999);
        chk("rst_mid_idle", {30'd0, busy, RAM_TAG_OE}, 32'd0);

        // Normal run after the reset
        for (int i = 0; i < 64; i++) cb_mem[i] = 24'h000040 + 24'(i);
        for (int k = 0; k < 4096; k++) tag_mem[k] = 24'(63 - (k % 64));
        do_run("post_rst");

`ifdef VQ_DECOMP_CHECKSUM_EN
        for (int i = 0; i < 64; i++) cb_mem[i] = 24'h123456;
        cb_mem[0] = 24'hFFFFFF;
        for (int k = 0; k < 4096; k++) tag_mem[k] = 24'h0;
        do_run("csum");
        chk("csum_value", checksum, 32'hFFFFF000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
